mem_access_stage: RTL and testbench

//  MEM stage sitting directly downstream of the EX/MEM pipeline register. Consumes its
//  ALU result (address), control bits and store data. Runs a valid/ready request and

---
 rtl/mem_access_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: valid/ready data-memory handshake, store lane steering, load alignment/extension.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (traps misaligned half/word accesses via out_misaligned).
module mem_access_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [2:0]      in_funct3,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [4:0]      in_rd,
  input  logic            in_write_enable,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [3:0]      dmem_req_be,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            out_misaligned,
`endif
  output logic            out_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_write_enable,
  output logic            out_bus_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [7:0]      tmo_cnt;
  logic [XLEN-1:0] lat_addr;
  logic [2:0]      lat_funct3;
  logic            lat_wen;

  logic            is_memop;
  logic            misaligned;
  logic            timeout_hit;
  logic [3:0]      next_be;
  logic [XLEN-1:0] next_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  assign is_memop       = in_valid & (in_mem_read | in_mem_write);
  assign timeout_hit    = (state != IDLE) && (tmo_cnt == TMO_LAST);
  assign dmem_req_valid = (state == REQ) && !timeout_hit;
  assign dmem_req_addr  = {lat_addr[XLEN-1:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (in_funct3[1:0] == 2'b01) ? in_alu_out[0]
                    : (in_funct3[1:0] != 2'b00) && (in_alu_out[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Store lane steering; funct3 values other than byte/half fall back to a full word.
  always_comb begin
    next_be    = 4'b1111;
    next_wdata = in_store_data;
    case (in_funct3[1:0])
      2'b00: begin
        next_be    = 4'b0001 << in_alu_out[1:0];
        next_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        next_be    = 4'b0011 << {in_alu_out[1], 1'b0};
        next_wdata = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = dmem_resp_rdata[{lat_addr[1:0], 3'b000} +: 8];
    ld_half   = dmem_resp_rdata[{lat_addr[1], 4'b0000} +: 16];
    load_data = dmem_resp_rdata;
    case (lat_funct3[1:0])
      2'b00:   load_data = {{(XLEN-8){~lat_funct3[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{(XLEN-16){~lat_funct3[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Stall drops in the completion (or abort) cycle so EX/MEM advances on that edge.
  always_comb begin
    out_stall = 1'b0;
    case (state)
      IDLE:    out_stall = is_memop & ~misaligned;
      REQ:     out_stall = ~timeout_hit & ~(dmem_req_ready & dmem_req_we);
      WAIT:    out_stall = ~timeout_hit & ~dmem_resp_valid;
      default: out_stall = 1'b0;
    endcase
    out_stall = out_stall & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      lat_addr         <= '0;
      lat_funct3       <= '0;
      lat_wen          <= 1'b0;
      dmem_req_we      <= 1'b0;
      dmem_req_wdata   <= '0;
      dmem_req_be      <= '0;
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_rd           <= '0;
      out_write_enable <= 1'b0;
      out_bus_error    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misaligned   <= 1'b0;
`endif
    end else begin
      out_valid        <= 1'b0;
      out_write_enable <= 1'b0;
      out_bus_error    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misaligned   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_rd <= in_rd;
            if (!(in_mem_read | in_mem_write)) begin
              out_valid        <= 1'b1;
              out_result       <= in_alu_out;
              out_write_enable <= in_write_enable;
            end else if (misaligned) begin
              out_valid      <= 1'b1;
              out_result     <= in_alu_out;
`ifdef MEM_MISALIGN_TRAP_EN
              out_misaligned <= 1'b1;
`endif
            end else begin
              lat_addr       <= in_alu_out;
              lat_funct3     <= in_funct3;
              lat_wen        <= in_write_enable;
              dmem_req_we    <= in_mem_write;
              dmem_req_be    <= next_be;
              dmem_req_wdata <= next_wdata;
              tmo_cnt        <= '0;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (timeout_hit) begin
            state         <= IDLE;
            out_valid     <= 1'b1;
            out_bus_error <= 1'b1;
            out_result    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (dmem_req_ready) begin
              if (dmem_req_we) begin
                state      <= IDLE;
                out_valid  <= 1'b1;
                out_result <= lat_addr;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (dmem_resp_valid) begin
            state            <= IDLE;
            out_valid        <= 1'b1;
            out_result       <= load_data;
            out_write_enable <= lat_wen;
          end else if (timeout_hit) begin
            state         <= IDLE;
            out_valid     <= 1'b1;
            out_bus_error <= 1'b1;
            out_result    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops against a reference model.
module tb_mem_access_stage;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [4:0]  in_rd;
  logic        in_write_enable;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        out_stall;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_write_enable;
  logic        out_bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        out_misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_alu_out       (in_alu_out),
    .in_store_data    (in_store_data),
    .in_funct3        (in_funct3),
    .in_mem_read      (in_mem_read),
    .in_mem_write     (in_mem_write),
    .in_rd            (in_rd),
    .in_write_enable  (in_write_enable),
    .dmem_req_valid   (dmem_req_valid),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_req_addr    (dmem_req_addr),
    .dmem_req_we      (dmem_req_we),
    .dmem_req_wdata   (dmem_req_wdata),
    .dmem_req_be      (dmem_req_be),
    .dmem_resp_valid  (dmem_resp_valid),
    .dmem_resp_rdata  (dmem_resp_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .out_misaligned   (out_misaligned),
`endif
    .out_stall        (out_stall),
    .out_valid        (out_valid),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .out_write_enable (out_write_enable),
    .out_bus_error    (out_bus_error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size 0=byte, 1=half, 2=word (unknown funct3 behaves as word)
  function automatic int sizeOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 0;
    if (f3[1:0] == 2'b01) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a[1:0]);
    case (sizeOf(f3))
      0:       return 4'(1 << off);
      1:       return 4'(3 << (2 * (off / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
    case (sizeOf(f3))
      0:       return (d & 32'hFF) * 32'h01010101;
      1:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int off = int'(a[1:0]);
    case (sizeOf(f3))
      0: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (!f3[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      1: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit modelMisaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    int off = int'(a[1:0]);
    case (sizeOf(f3))
      0:       return 1'b0;
      1:       return (off % 2) != 0;
      default: return off != 0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic applyBubble();
    in_valid      = 1'b0;
    in_alu_out    = $urandom();
    in_mem_read   = 1'($urandom_range(0, 1));
    in_mem_write  = 1'($urandom_range(0, 1));
    in_write_enable = 1'b1;
    #1;
    checkOutput("bubble_stall", 32'(out_stall), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("bubble_we", 32'(out_write_enable), 32'd0);
  endtask

  // Presents one instruction and follows it to its MEM/WB result; called at a negedge.
  task automatic applyStimulus(input string tag, input bit rd_op, input bit wr_op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                               input bit wen, input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    bit memop, store, trap, completes, fin, aborted;
    int resp_j;
    memop = rd_op | wr_op;
    store = wr_op;
    trap  = memop && modelMisaligned(f3, addr);
    in_valid = 1'b1; in_alu_out = addr; in_store_data = sdata; in_funct3 = f3;
    in_mem_read = rd_op; in_mem_write = wr_op; in_rd = rd; in_write_enable = wen;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    #1;
    checkOutput({tag, "_issue_stall"}, 32'(out_stall), 32'(memop && !trap));
    checkOutput({tag, "_issue_reqv"}, 32'(dmem_req_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    if (!memop || trap) begin
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_rd"}, 32'(out_rd), 32'(rd));
      checkOutput({tag, "_we"}, 32'(out_write_enable), trap ? 32'd0 : 32'(wen));
      checkOutput({tag, "_result"}, out_result, addr);
      checkOutput({tag, "_berr"}, 32'(out_bus_error), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
      checkOutput({tag, "_misal"}, 32'(out_misaligned), 32'(trap));
`endif
      return;
    end
    resp_j  = rdy_dly + 1 + rsp_dly;
    fin     = 1'b0;
    aborted = 1'b0;
    for (int j = 0; j < TMO && !fin; j++) begin
      dmem_req_ready  = (j == rdy_dly);
      dmem_resp_valid = (!store && j == resp_j) || (j <= rdy_dly && $urandom_range(0, 3) == 0);
      dmem_resp_rdata = (j == resp_j) ? rdata : $urandom();
      completes = store ? (j == rdy_dly && j < TMO - 1) : (j == resp_j);
      fin = completes || (j == TMO - 1);
      #1;
      checkOutput({tag, "_stall"}, 32'(out_stall), 32'(!fin));
      checkOutput({tag, "_reqv"}, 32'(dmem_req_valid), 32'(j <= rdy_dly && j < TMO - 1));
      if (j == 0) begin
        checkOutput({tag, "_addr"}, dmem_req_addr, addr & 32'hFFFF_FFFC);
        checkOutput({tag, "_reqwe"}, 32'(dmem_req_we), 32'(store));
        checkOutput({tag, "_be"}, 32'(dmem_req_be), 32'(modelBe(f3, addr)));
        if (store) checkOutput({tag, "_wdata"}, dmem_req_wdata, modelWdata(f3, sdata));
      end
      aborted = !completes;
      @(posedge clk); @(negedge clk);
    end
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_berr"}, 32'(out_bus_error), 32'(aborted));
    checkOutput({tag, "_we"}, 32'(out_write_enable), (aborted || store) ? 32'd0 : 32'(wen));
    if (aborted) checkOutput({tag, "_result"}, out_result, 32'd0);
    else if (!store) begin
      checkOutput({tag, "_result"}, out_result, modelLoad(f3, addr, rdata));
      checkOutput({tag, "_rd"}, 32'(out_rd), 32'(rd));
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_alu_out = '0; in_store_data = '0; in_funct3 = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_rd = '0; in_write_enable = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_stall", 32'(out_stall), 32'd0);
    checkOutput("rst_reqv", 32'(dmem_req_valid), 32'd0);
    checkOutput("rst_result", out_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus("add", 0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 32'h0);
    applyStimulus("sb", 0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd7, 1, 0, 0, 32'h0);
    checkOutput("sb_be_const", 32'(modelBe(3'b000, 32'h1003)), 32'h8);
    applyStimulus("lb", 1, 0, 3'b000, 32'h0000_2002, 32'h0, 5'd9, 1, 0, 2, 32'h0080_FF00);
    applyStimulus("lbu", 1, 0, 3'b100, 32'h0000_2002, 32'h0, 5'd9, 1, 1, 2, 32'h0080_FF00);
    applyStimulus("lh_tmo", 1, 0, 3'b001, 32'h0000_2002, 32'h0, 5'd3, 1, 200, 0, 32'h0);
    applyBubble();
    applyStimulus("lw_tmo", 1, 0, 3'b010, 32'h0000_4000, 32'h0, 5'd4, 1, 0, 200, 32'h0);
    applyStimulus("sh_late", 0, 1, 3'b001, 32'h0000_5002, 32'hDEAD_BEEF, 5'd1, 1, 5, 0, 32'h0);
    applyStimulus("rdwr", 1, 1, 3'b010, 32'h0000_6000, 32'h1357_9BDF, 5'd2, 1, 1, 0, 32'h0);

    // Reset while a load waits for its response
    in_valid = 1'b1; in_alu_out = 32'h0000_7001; in_funct3 = 3'b000;
    in_mem_read = 1'b1; in_mem_write = 1'b0; in_rd = 5'd12; in_write_enable = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("rstmid_stall", 32'(out_stall), 32'd0);
    checkOutput("rstmid_reqv", 32'(dmem_req_valid), 32'd0);
    checkOutput("rstmid_addr", dmem_req_addr, 32'd0);
    checkOutput("rstmid_result", out_result, 32'd0);
    in_valid = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_resp_valid = 1'b0;
    checkOutput("rstmid_after_valid", 32'(out_valid), 32'd0);
    applyStimulus("post_rst", 1, 0, 3'b101, 32'h0000_7002, 32'h0, 5'd12, 1, 0, 0, 32'h8001_0000);

`ifdef MEM_MISALIGN_TRAP_EN
    applyStimulus("lw_misal", 1, 0, 3'b010, 32'h0000_3001, 32'h0, 5'd6, 1, 0, 0, 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 4);
      if (kind == 4) applyBubble();
      else applyStimulus($sformatf("rnd%0d", i), kind == 1 || kind == 3, kind == 2 || kind == 3,
                         3'($urandom_range(0, 7)), $urandom(), $urandom(), 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
    end
    applyBubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
